// File: rtl/sid_waveform_mixer_pkg.sv
// ============================================================================
// Package : sid
// Purpose : Shared types, indices and helpers for the SID waveform mixer.
//           Provides chip model / phase / waveform bus typedefs, the
//           selector bit indices and the combined-waveform table function
//           used by sid_combined_rom (build macro SID_COMBINED_ROM_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sid;

  typedef logic [11:0] reg12_t;

  typedef enum logic {
    MOS6581 = 1'b0,
    MOS8580 = 1'b1
  } model_e;

  // One-hot SID cycle phase strobes
  localparam int PHI1 = 0;
  localparam int PHI2 = 1;
  typedef logic [1:0] phase_t;

  // Selector bit indices: {noise, pulse, saw, tri}
  localparam int WAVE_TRI = 0;
  localparam int WAVE_SAW = 1;
  localparam int WAVE_PUL = 2;
  localparam int WAVE_NOI = 3;

  typedef struct packed {
    logic [3:0] selector;
    logic [7:0] noise;
    logic       pulse;
    reg12_t     saw_tri;
  } waveform_i_t;

  typedef struct packed {
    reg12_t     wave;
    logic [7:0] noise_wb;
  } waveform_o_t;

  // Combined-table page for a tri/saw/pulse selector with >=2 bits set:
  // 0 = saw+tri, 1 = pulse+saw, 2 = pulse+tri, 3 = pulse+saw+tri.
  function automatic logic [1:0] sel_ts_ps(input logic [2:0] sel);
    logic [1:0] page;
    page = 2'd0;
    case (sel)
      3'b011:  page = 2'd0;
      3'b110:  page = 2'd1;
      3'b101:  page = 2'd2;
      3'b111:  page = 2'd3;
      default: page = 2'd0;
    endcase
    return page;
  endfunction

  // Table entry with pulse held high (the mixer ANDs in PUL afterwards).
  // Analytic stand-in for the measured reSID tables: on the 6581 a set bit
  // survives only when a neighbouring bit is also set, mimicking the
  // stronger pull-down between adjacent DAC bits; the 8580 keeps the AND.
  function automatic reg12_t combined_entry(input model_e m,
                                            input logic [1:0] page,
                                            input reg12_t st);
    reg12_t tri_v;
    reg12_t base;
    tri_v = {st[10:0], 1'b0};
    base  = '0;
    case (page)
      2'd0:    base = st & tri_v;
      2'd1:    base = st;
      2'd2:    base = tri_v;
      default: base = st & tri_v;
    endcase
    if (m == MOS6581) begin
      base = base & ((base << 1) | (base >> 1));
    end
    return base;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sid_waveform_mixer_combined_rom.sv
// ============================================================================
// Module  : sid_combined_rom
// Purpose : Per-model 4096x12 combined-waveform tables, synchronous read.
//           Only instantiated when SID_COMBINED_ROM_EN is defined.
// Ports   : clk, res_n (sync active-low), rd_en_i (PHI1 strobe),
//           addr_i {model, page[1:0], saw_tri[11:0]}, data_o (1-clk latency)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sid_combined_rom
  import sid::*;
(
  input  logic        clk,
  input  logic        res_n,
  input  logic        rd_en_i,
  input  logic [14:0] addr_i,
  output reg12_t      data_o
);

  reg12_t data_q;
  model_e addr_model;

  assign addr_model = model_e'(addr_i[14]);

  always_ff @(posedge clk) begin
    if (!res_n) begin
      data_q <= '0;
    end else if (rd_en_i) begin
      data_q <= combined_entry(addr_model, addr_i[13:12], addr_i[11:0]);
    end
  end

  assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/sid_waveform_mixer.sv
// ============================================================================
// Module  : sid_waveform_mixer
// Purpose : Waveform selector / DAC input stage. Registers the oscillator
//           waveform bus at PHI1, resolves single or combined waveforms and
//           updates the DAC value at PHI2 (one SID cycle latency). With no
//           waveform selected the output floats: it is held, and after a
//           model-dependent time-to-live it fades by one bit per millisecond.
// Ports   : clk, res_n (sync active-low), tick_ms (1 ms strobe), model,
//           phase (one-hot PHI1/PHI2), wave_i (waveform bus),
//           wave_o (12-bit DAC value), noise_wb (LFSR writeback mask)
// Config  : SID_COMBINED_ROM_EN - combined tri/saw/pulse values come from
//           per-model tables instead of a plain bitwise AND.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sid_waveform_mixer
  import sid::*;
#(
  parameter logic [13:0] FADE_TTL_6581 = 14'd54,
  parameter logic [13:0] FADE_TTL_8580 = 14'd800
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        tick_ms,
  input  model_e      model,
  input  phase_t      phase,
  input  waveform_i_t wave_i,
  output reg12_t      wave_o,
  output logic [7:0]  noise_wb
);

  waveform_i_t in_q;
  model_e      model_q;
  waveform_o_t out_q, out_d;
  logic [13:0] fade_cnt_q, fade_cnt_d;

  reg12_t      w_tri, w_saw, w_pul, w_noi, w_mixed;
  logic [3:0]  w_sel_live;
  logic        w_floating;
  logic [13:0] w_ttl;

  assign w_tri = {in_q.saw_tri[10:0], 1'b0};
  assign w_saw = in_q.saw_tri;
  assign w_pul = {12{in_q.pulse}};
  assign w_noi = {in_q.noise, 4'b0000};

  // A nonzero selector arriving with PHI1 already ends the floating state,
  // so it beats a tick_ms on the same clock.
  assign w_sel_live = phase[PHI1] ? wave_i.selector : in_q.selector;
  assign w_floating = (w_sel_live == 4'd0);
  assign w_ttl      = (model_q == MOS8580) ? FADE_TTL_8580 : FADE_TTL_6581;

`ifdef SID_COMBINED_ROM_EN
  reg12_t w_rom_data;
  reg12_t w_base;

  sid_combined_rom u_rom (
    .clk     (clk),
    .res_n   (res_n),
    .rd_en_i (phase[PHI1]),
    .addr_i  ({model, sel_ts_ps(wave_i.selector[2:0]), wave_i.saw_tri}),
    .data_o  (w_rom_data)
  );

  always_comb begin
    w_base = 12'hfff;
    if ($countones(in_q.selector[2:0]) >= 2) begin
      w_base = w_rom_data & (in_q.selector[WAVE_PUL] ? w_pul : 12'hfff);
    end else if (in_q.selector[WAVE_TRI]) begin
      w_base = w_tri;
    end else if (in_q.selector[WAVE_SAW]) begin
      w_base = w_saw;
    end else if (in_q.selector[WAVE_PUL]) begin
      w_base = w_pul;
    end
    w_mixed = in_q.selector[WAVE_NOI] ? (w_base & w_noi) : w_base;
  end
`else
  always_comb begin
    w_mixed = 12'hfff;
    if (in_q.selector[WAVE_TRI]) w_mixed = w_mixed & w_tri;
    if (in_q.selector[WAVE_SAW]) w_mixed = w_mixed & w_saw;
    if (in_q.selector[WAVE_PUL]) w_mixed = w_mixed & w_pul;
    if (in_q.selector[WAVE_NOI]) w_mixed = w_mixed & w_noi;
  end
`endif

  always_comb begin
    out_d      = out_q;
    fade_cnt_d = fade_cnt_q;
    if (w_floating) begin
      if (phase[PHI2]) begin
        out_d.noise_wb = 8'hff;
      end
      if (tick_ms) begin
        if (fade_cnt_q != 14'h3fff) begin
          fade_cnt_d = fade_cnt_q + 14'd1;
        end
        // Compare the pre-increment count: the tick that reaches TTL
        // still holds, the one after it starts fading.
        if (fade_cnt_q >= w_ttl) begin
          out_d.wave = out_q.wave >> 1;
        end
      end
    end else begin
      fade_cnt_d = '0;
      if (phase[PHI2]) begin
        out_d.wave     = w_mixed;
        out_d.noise_wb = (in_q.selector[WAVE_NOI] && (in_q.selector[2:0] != 3'd0))
                         ? w_mixed[11:4] : 8'hff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      in_q           <= '0;
      model_q        <= MOS6581;
      out_q.wave     <= '0;
      out_q.noise_wb <= 8'hff;
      fade_cnt_q     <= '0;
    end else begin
      if (phase[PHI1]) begin
        in_q    <= wave_i;
        model_q <= model;
      end
      out_q      <= out_d;
      fade_cnt_q <= fade_cnt_d;
    end
  end

  assign wave_o   = out_q.wave;
  assign noise_wb = out_q.noise_wb;

endmodule

`default_nettype wire

// File: tb/tb_sid_waveform_mixer.sv
// ============================================================================
// Module  : tb_sid_waveform_mixer
// Purpose : Directed self-checking bench for sid_waveform_mixer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sid_waveform_mixer;
  import sid::*;

  logic        clk = 1'b0;
  logic        res_n;
  logic        tick_ms;
  model_e      model;
  phase_t      phase;
  waveform_i_t wave_i;
  reg12_t      wave_o;
  logic [7:0]  noise_wb;

  int checks = 0;
  int errors = 0;

  sid_waveform_mixer dut (
    .clk      (clk),
    .res_n    (res_n),
    .tick_ms  (tick_ms),
    .model    (model),
    .phase    (phase),
    .wave_i   (wave_i),
    .wave_o   (wave_o),
    .noise_wb (noise_wb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_wave(input logic [3:0] sel, input logic [7:0] noi,
                          input logic pul, input logic [11:0] st);
    wave_i.selector = sel;
    wave_i.noise    = noi;
    wave_i.pulse    = pul;
    wave_i.saw_tri  = st;
  endtask

  // One SID cycle: PHI1 strobe, idle, PHI2 strobe, idle.
  task automatic sid_cycle();
    phase = 2'b01; @(negedge clk);
    phase = 2'b00; @(negedge clk);
    phase = 2'b10; @(negedge clk);
    phase = 2'b00; @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_ms = 1'b1; @(negedge clk);
      tick_ms = 1'b0; @(negedge clk);
    end
  endtask

  // Load a value through SAW, then deselect everything so it floats.
  task automatic load_and_float(input logic [11:0] v);
    set_wave(4'b0010, 8'h00, 1'b0, v);
    sid_cycle();
    set_wave(4'b0000, 8'h00, 1'b0, 12'h000);
    sid_cycle();
  endtask

  initial begin
    res_n   = 1'b0;
    tick_ms = 1'b0;
    model   = MOS6581;
    phase   = 2'b00;
    set_wave(4'b0000, 8'h00, 1'b0, 12'h000);
    @(negedge clk); @(negedge clk);
    check("reset_wave", wave_o, 12'h000);
    check("reset_wb", noise_wb, 8'hff);
    check("reset_cnt", dut.fade_cnt_q, 14'd0);
    res_n = 1'b1;

    set_wave(4'b0010, 8'h00, 1'b0, 12'h123); sid_cycle();
    check("saw", wave_o, 12'h123);
    check("saw_wb", noise_wb, 8'hff);
    set_wave(4'b0001, 8'h00, 1'b0, 12'h9ab); sid_cycle();
    check("tri", wave_o, 12'h356);
    set_wave(4'b0100, 8'h00, 1'b1, 12'h000); sid_cycle();
    check("pul", wave_o, 12'hfff);
    set_wave(4'b1000, 8'ha5, 1'b0, 12'h000); sid_cycle();
    check("noi", wave_o, 12'ha50);
    check("noi_wb", noise_wb, 8'hff);
    set_wave(4'b1010, 8'hff, 1'b0, 12'h0f0); sid_cycle();
    check("noi_saw", wave_o, 12'h0f0);
    check("noi_saw_wb", noise_wb, 8'h0f);
    set_wave(4'b1100, 8'h3c, 1'b1, 12'h000); sid_cycle();
    check("noi_pul", wave_o, 12'h3c0);
    check("noi_pul_wb", noise_wb, 8'h3c);
`ifndef SID_COMBINED_ROM_EN
    set_wave(4'b0011, 8'h00, 1'b0, 12'h7ff); sid_cycle();
    check("tri_saw_and", wave_o, 12'h7fe);
    check("tri_saw_wb", noise_wb, 8'hff);
`endif

    // 6581 hold then fade
    load_and_float(12'h800);
    check("float_hold", wave_o, 12'h800);
    check("float_wb", noise_wb, 8'hff);
    ticks(54);
    check("6581_tick54", wave_o, 12'h800);
    for (int k = 1; k <= 12; k++) begin
      ticks(1);
      check("6581_fade", wave_o, 32'h800 >> k);
    end
    ticks(2);
    check("6581_zero", wave_o, 12'h000);

    // Reset mid-hold with counter 30, phase strobes asserted
    load_and_float(12'hfff);
    ticks(30);
    check("cnt30", dut.fade_cnt_q, 14'd30);
    set_wave(4'b0010, 8'h00, 1'b0, 12'h555);
    res_n = 1'b0; phase = 2'b11; @(negedge clk);
    res_n = 1'b1; phase = 2'b00;
    set_wave(4'b0000, 8'h00, 1'b0, 12'h000);
    check("rst_mid_wave", wave_o, 12'h000);
    check("rst_mid_wb", noise_wb, 8'hff);
    check("rst_mid_cnt", dut.fade_cnt_q, 14'd0);

    // Selector change coincident with tick_ms at TTL
    load_and_float(12'h800);
    ticks(54);
    set_wave(4'b0010, 8'h00, 1'b0, 12'h123);
    phase = 2'b01; tick_ms = 1'b1; @(negedge clk);
    phase = 2'b00; tick_ms = 1'b0;
    check("coinc_cnt", dut.fade_cnt_q, 14'd0);
    check("coinc_nofade", wave_o, 12'h800);
    phase = 2'b10; @(negedge clk); phase = 2'b00; @(negedge clk);
    check("coinc_new", wave_o, 12'h123);

    // 8580 hold
    model = MOS8580;
    load_and_float(12'h800);
    ticks(54);
    check("8580_tick54", wave_o, 12'h800);
    ticks(746);
    check("8580_tick800", wave_o, 12'h800);
    ticks(1);
    check("8580_tick801", wave_o, 12'h400);

    // Model change mid-hold: counter 100 is already past the 6581 TTL
    load_and_float(12'h800);
    ticks(100);
    check("8580_tick100", wave_o, 12'h800);
    model = MOS6581;
    phase = 2'b01; @(negedge clk); phase = 2'b00; @(negedge clk);
    check("model_sw_hold", wave_o, 12'h800);
    ticks(1);
    check("model_sw_fade", wave_o, 12'h400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
